// File: rtl/jb_cplane_bid_pkg.sv
// Shared types and helpers for the C-plane beam-ID receive path.
package jb_cplane_bid_pkg;

    // Largest number of symbols one beam-ID record may cover.
    localparam int MAX_SYMBOL = 14;

    // One record as it is held in the FIFO and in the egress record register.
    // all_prb is decoded once at ingress so the egress side only forwards it.
    typedef struct packed {
        logic [14:0] beamid15;
        logic [7:0]  cc_id;
        logic [7:0]  num_prbc;
        logic        all_prb;
        logic [3:0]  num_symbol;
        logic        rb;
        logic [11:0] remask;
        logic [9:0]  start_prbc;
        logic        tlast;
    } bid_rec_t;

    // Egress sequencer states.
    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } bid_state_e;

    // A record is usable only when it covers 1..MAX_SYMBOL symbols.
    function automatic logic is_legal_rec(input logic [3:0] num_symbol);
        return (num_symbol != 4'd0) && (num_symbol <= 4'(MAX_SYMBOL));
    endfunction

endpackage

// File: rtl/jb_sync_fifo.sv
// Single-clock ring-buffer FIFO; the head entry is presented straight from
// the register array and the level is also offered one cycle early.
module jb_sync_fifo #(
    parameter int WIDTH = 60,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [$clog2(DEPTH):0]   level_nxt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Popping an empty FIFO is ignored; a push into a full FIFO is allowed
    // only when the head leaves in the same cycle, which frees its slot.
    always_comb begin
        full    = (level_q == LVL_W'(DEPTH));
        do_pop  = pop_i && (level_q != '0);
        do_push = push_i && (!full || do_pop);
        level_d = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
    end

    // Storage array needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            level_q <= level_d;
        end
    end

    assign head_o      = mem_q[rd_ptr_q];
    assign empty_o     = (level_q == '0);
    assign level_o     = level_q;
    assign level_nxt_o = level_d;

endmodule

// File: rtl/jb_cplane_bid_rx.sv
// Receives beam-ID records from the fronthaul C-plane parser, buffers them
// and replays each record once per symbol towards the beam-weight lookup.
module jb_cplane_bid_rx
    import jb_cplane_bid_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [14:0]            in_beamid15,
    input  logic [7:0]             in_cc_id,
    input  logic [7:0]             in_num_prbc,
    input  logic [3:0]             in_num_symbol,
    input  logic                   in_rb,
    input  logic [11:0]            in_remask,
    input  logic [9:0]             in_start_prbc,
    input  logic                   in_tlast,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [14:0]            out_beamid15,
    output logic [7:0]             out_cc_id,
    output logic [9:0]             out_start_prbc,
    output logic [7:0]             out_num_prbc,
    output logic                   out_all_prb,
    output logic                   out_rb,
    output logic [11:0]            out_remask,
    output logic [3:0]             out_sym_idx,
    output logic                   out_sym_last,
    output logic                   out_set_last,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [CNT_W-1:0]       rec_cnt,
    output logic [CNT_W-1:0]       drop_cnt
);

    localparam int LVL_W = $clog2(DEPTH) + 1;

    bid_rec_t         in_rec;
    logic             in_fire;
    logic             in_legal;
    logic             push;
    bid_rec_t         head;
    logic [$bits(bid_rec_t)-1:0] head_bits;
    logic             fifo_empty;
    logic [LVL_W-1:0] level_nxt;
    logic             pop;
    logic             sym_last;

    logic             in_ready_q;
    logic             in_ready_d;
    logic [CNT_W-1:0] rec_cnt_q;
    logic [CNT_W-1:0] rec_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q;
    logic [CNT_W-1:0] drop_cnt_d;

    bid_state_e       state_q;
    bid_rec_t         rec_q;
    logic [3:0]       sym_q;
    logic             out_valid_q;

    // Pack the incoming record and decide whether it is worth storing.
    always_comb begin
        in_rec            = '0;
        in_rec.beamid15   = in_beamid15;
        in_rec.cc_id      = in_cc_id;
        in_rec.num_prbc   = in_num_prbc;
        in_rec.all_prb    = (in_num_prbc == 8'd0);
        in_rec.num_symbol = in_num_symbol;
        in_rec.rb         = in_rb;
        in_rec.remask     = in_remask;
        in_rec.start_prbc = in_start_prbc;
        in_rec.tlast      = in_tlast;
        in_fire           = in_valid && in_ready;
        in_legal          = is_legal_rec(in_num_symbol);
        push              = in_fire && in_legal;
    end

    jb_sync_fifo #(
        .WIDTH($bits(bid_rec_t)),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (in_rec),
        .pop_i       (pop),
        .head_o      (head_bits),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level),
        .level_nxt_o (level_nxt)
    );

    assign head = bid_rec_t'(head_bits);

    // Pull a record either when idle or when the current one finishes its
    // last symbol, so consecutive records stream without a gap.
    always_comb begin
        sym_last = (sym_q == (rec_q.num_symbol - 4'd1));
        pop      = 1'b0;
        case (state_q)
            IDLE:    pop = !fifo_empty;
            EMIT:    pop = out_valid_q && out_ready && sym_last && !fifo_empty;
            default: pop = 1'b0;
        endcase
    end

    // Ready and counter next-state; ready looks at next cycle's level so it
    // never depends combinationally on out_ready.
    always_comb begin
        in_ready_d = (level_nxt < LVL_W'(DEPTH));
        rec_cnt_d  = rec_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (push && (rec_cnt_q != '1)) begin
            rec_cnt_d = rec_cnt_q + CNT_W'(1);
        end
        if (in_fire && !in_legal && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    // Ingress ready flag and saturating status counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_q <= 1'b1;
            rec_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            in_ready_q <= in_ready_d;
            rec_cnt_q  <= rec_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Egress sequencer: loads a record, then walks its symbols one beat at a
    // time, holding every field while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rec_q       <= '0;
            sym_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        rec_q       <= head;
                        sym_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (!sym_last) begin
                            sym_q <= sym_q + 4'd1;
                        end else if (pop) begin
                            rec_q <= head;
                            sym_q <= '0;
                        end else begin
                            out_valid_q <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready       = in_ready_q && !rst;
    assign out_valid      = out_valid_q;
    assign out_beamid15   = rec_q.beamid15;
    assign out_cc_id      = rec_q.cc_id;
    assign out_start_prbc = rec_q.start_prbc;
    assign out_num_prbc   = rec_q.num_prbc;
    assign out_all_prb    = rec_q.all_prb;
    assign out_rb         = rec_q.rb;
    assign out_remask     = rec_q.remask;
    assign out_sym_idx    = sym_q;
    assign out_sym_last   = sym_last;
    assign out_set_last   = sym_last && rec_q.tlast;
    assign rec_cnt        = rec_cnt_q;
    assign drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_jb_cplane_bid_rx.sv
// Bench for jb_cplane_bid_rx: directed scenarios plus a randomized run, all
// beats checked against a queue of expected per-symbol descriptors.
module tb_jb_cplane_bid_rx;

    typedef struct packed {
        logic [14:0] beam;
        logic [7:0]  cc;
        logic [7:0]  nprb;
        logic [3:0]  nsym;
        logic        rb;
        logic [11:0] remask;
        logic [9:0]  sprb;
        logic        tlast;
    } rec_t;

    logic        clk;
    logic        rst;
    logic [14:0] in_beamid15;
    logic [7:0]  in_cc_id;
    logic [7:0]  in_num_prbc;
    logic [3:0]  in_num_symbol;
    logic        in_rb;
    logic [11:0] in_remask;
    logic [9:0]  in_start_prbc;
    logic        in_tlast;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] out_beamid15;
    logic [7:0]  out_cc_id;
    logic [9:0]  out_start_prbc;
    logic [7:0]  out_num_prbc;
    logic        out_all_prb;
    logic        out_rb;
    logic [11:0] out_remask;
    logic [3:0]  out_sym_idx;
    logic        out_sym_last;
    logic        out_set_last;
    logic [3:0]  fifo_level;
    logic [15:0] rec_cnt;
    logic [15:0] drop_cnt;

    int          checks = 0;
    int          failures = 0;
    logic [63:0] exp_q[$];
    int          mRec = 0;
    int          mDrop = 0;
    int          beatsSeen = 0;
    int          run = 0;
    int          maxRun = 0;
    bit          stallPrev = 0;
    logic [63:0] prevVec = '0;
    bit          sendDone = 0;

    jb_cplane_bid_rx #(.DEPTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_beamid15(in_beamid15), .in_cc_id(in_cc_id), .in_num_prbc(in_num_prbc),
        .in_num_symbol(in_num_symbol), .in_rb(in_rb), .in_remask(in_remask),
        .in_start_prbc(in_start_prbc), .in_tlast(in_tlast), .in_valid(in_valid),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_beamid15(out_beamid15), .out_cc_id(out_cc_id), .out_start_prbc(out_start_prbc),
        .out_num_prbc(out_num_prbc), .out_all_prb(out_all_prb), .out_rb(out_rb),
        .out_remask(out_remask), .out_sym_idx(out_sym_idx), .out_sym_last(out_sym_last),
        .out_set_last(out_set_last), .fifo_level(fifo_level), .rec_cnt(rec_cnt),
        .drop_cnt(drop_cnt)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] obsVec();
        return 64'({out_beamid15, out_cc_id, out_start_prbc, out_num_prbc, out_all_prb,
                    out_rb, out_remask, out_sym_idx, out_sym_last, out_set_last});
    endfunction

    // Expected beats of a legal record: one per symbol, in symbol order.
    function automatic void pushBeats(input rec_t r);
        for (int s = 0; s < int'(r.nsym); s++) begin
            exp_q.push_back(64'({r.beam, r.cc, r.sprb, r.nprb, (r.nprb == 8'd0), r.rb,
                                 r.remask, 4'(s), (s == int'(r.nsym) - 1),
                                 (s == int'(r.nsym) - 1) && r.tlast}));
        end
    endfunction

    function automatic rec_t mkRec(input logic [14:0] beam, input logic [3:0] nsym, input logic tlast);
        rec_t r;
        r.beam   = beam;
        r.cc     = 8'($urandom);
        r.nprb   = 8'($urandom);
        r.nsym   = nsym;
        r.rb     = 1'($urandom);
        r.remask = 12'($urandom);
        r.sprb   = 10'($urandom);
        r.tlast  = tlast;
        return r;
    endfunction

    // Model and monitor: mid-cycle sampling of both handshakes, counters and
    // the hold-while-stalled rule.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            mRec = 0;
            mDrop = 0;
            beatsSeen = 0;
            run = 0;
            maxRun = 0;
            stallPrev = 0;
        end else begin
            checkOutput("rec_cnt", 64'(rec_cnt), 64'(mRec));
            checkOutput("drop_cnt", 64'(drop_cnt), 64'(mDrop));
            if (in_valid && in_ready) begin
                if (in_num_symbol >= 4'd1 && in_num_symbol <= 4'd14) begin
                    mRec = (mRec == 65535) ? mRec : mRec + 1;
                    pushBeats('{in_beamid15, in_cc_id, in_num_prbc, in_num_symbol, in_rb,
                                in_remask, in_start_prbc, in_tlast});
                end else begin
                    mDrop = (mDrop == 65535) ? mDrop : mDrop + 1;
                end
            end
            if (stallPrev) begin
                checkOutput("stall_hold", {out_valid, obsVec()}, {1'b1, prevVec});
            end
            if (out_valid && out_ready) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    failures++;
                    $error("[TB] FAIL beat_unexpected: observed=%0h expected=none", obsVec());
                end
                if (exp_q.size() != 0) begin
                    checkOutput("beat", obsVec(), exp_q.pop_front());
                end
                beatsSeen++;
            end
            run = out_valid ? run + 1 : 0;
            if (run > maxRun) maxRun = run;
            stallPrev = out_valid && !out_ready;
            prevVec = obsVec();
        end
    end

    task automatic applyStimulus(input rec_t r, output int waits);
        bit acc;
        acc = 0;
        waits = 0;
        in_beamid15 = r.beam;
        in_cc_id = r.cc;
        in_num_prbc = r.nprb;
        in_num_symbol = r.nsym;
        in_rb = r.rb;
        in_remask = r.remask;
        in_start_prbc = r.sprb;
        in_tlast = r.tlast;
        in_valid = 1'b1;
        while (!acc && waits < 400) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (!acc) waits++;
        end
        in_valid = 1'b0;
        checkOutput("in_accept", 64'(acc), 64'(1));
    endtask

    task automatic resetDut();
        rst = 1'b1;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic waitDrain(input int budget, input bit randReady);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < budget) begin
            @(posedge clk);
            #1;
            if (randReady) out_ready = ($urandom_range(0, 3) != 0);
            n++;
        end
        out_ready = 1'b1;
        checkOutput("drain", 64'(exp_q.size()), 64'(0));
        checkOutput("drain_idle", 64'(out_valid), 64'(0));
    endtask

    initial begin
        int w;
        int n;
        rec_t r;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_beamid15 = '0; in_cc_id = '0; in_num_prbc = '0; in_num_symbol = '0;
        in_rb = 1'b0; in_remask = '0; in_start_prbc = '0; in_tlast = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] reset state");
        @(negedge clk);
        checkOutput("rst_in_ready", 64'(in_ready), 64'(0));
        checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
        checkOutput("rst_fields", obsVec(), 64'(0));
        checkOutput("rst_level", 64'(fifo_level), 64'(0));
        checkOutput("rst_rec_cnt", 64'(rec_cnt), 64'(0));
        checkOutput("rst_drop_cnt", 64'(drop_cnt), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_rst", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;

        $display("[TB] single record");
        resetDut();
        out_ready = 1'b1;
        applyStimulus(mkRec(15'h1234, 4'd3, 1'b1), w);
        waitDrain(100, 0);
        checkOutput("single_beats", 64'(beatsSeen), 64'(3));
        checkOutput("single_rec_cnt", 64'(rec_cnt), 64'(1));

        $display("[TB] back-to-back");
        resetDut();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(mkRec(15'($urandom), 4'd1, 1'($urandom)), w);
            checkOutput("b2b_no_wait", 64'(w), 64'(0));
        end
        waitDrain(100, 0);
        checkOutput("b2b_run", 64'(maxRun), 64'(4));

        $display("[TB] backpressure to full");
        resetDut();
        for (int i = 0; i < 9; i++) begin
            applyStimulus(mkRec(15'($urandom), 4'd14, 1'(i == 8)), w);
        end
        @(negedge clk);
        checkOutput("full_in_ready", 64'(in_ready), 64'(0));
        checkOutput("full_level", 64'(fifo_level), 64'(8));
        repeat (3) @(posedge clk);
        #1;
        checkOutput("full_level_hold", 64'(fifo_level), 64'(8));
        waitDrain(3000, 1);
        checkOutput("full_beats", 64'(beatsSeen), 64'(126));
        checkOutput("full_rec_cnt", 64'(rec_cnt), 64'(9));

        $display("[TB] illegal records");
        resetDut();
        out_ready = 1'b1;
        applyStimulus(mkRec(15'h0111, 4'd0, 1'b0), w);
        applyStimulus(mkRec(15'h0222, 4'd15, 1'b0), w);
        applyStimulus(mkRec(15'h0333, 4'd2, 1'b1), w);
        waitDrain(100, 0);
        checkOutput("illegal_drop", 64'(drop_cnt), 64'(2));
        checkOutput("illegal_rec", 64'(rec_cnt), 64'(1));
        checkOutput("illegal_beats", 64'(beatsSeen), 64'(2));

        $display("[TB] all-PRB record");
        resetDut();
        r = mkRec(15'h7ABC, 4'd1, 1'b1);
        r.nprb = 8'd0;
        r.sprb = 10'h3FF;
        applyStimulus(r, w);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("allprb_flag", 64'(out_all_prb), 64'(1));
        checkOutput("allprb_nprb", 64'(out_num_prbc), 64'(0));
        checkOutput("allprb_sprb", 64'(out_start_prbc), 64'h3FF);
        out_ready = 1'b1;
        waitDrain(100, 0);

        $display("[TB] reset mid-record");
        resetDut();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(mkRec(15'($urandom), 4'd14, 1'b0), w);
        end
        out_ready = 1'b1;
        n = 0;
        while (!(out_valid && out_sym_idx == 4'd5) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("reach_sym5", 64'(out_sym_idx), 64'(5));
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("midrst_out_valid", 64'(out_valid), 64'(0));
        checkOutput("midrst_level", 64'(fifo_level), 64'(0));
        checkOutput("midrst_rec_cnt", 64'(rec_cnt), 64'(0));
        checkOutput("midrst_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_ready_back", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        applyStimulus(mkRec(15'h0555, 4'd3, 1'b1), w);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("post_rst_sym", 64'(out_sym_idx), 64'(0));
        out_ready = 1'b1;
        waitDrain(100, 0);
        checkOutput("post_rst_beats", 64'(beatsSeen), 64'(3));

        $display("[TB] randomized traffic");
        resetDut();
        sendDone = 0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    applyStimulus(mkRec(15'($urandom), 4'($urandom_range(0, 15)), 1'($urandom)), w);
                end
                sendDone = 1;
            end
            begin
                while (!sendDone) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        waitDrain(5000, 1);
        checkOutput("rand_total", 64'(int'(rec_cnt) + int'(drop_cnt)), 64'(40));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
